// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed 4-digit 7-segment scanner for packed BCD
module bcd_display_scanner #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_number,
    input  logic        load,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]     AN_OFF   = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic           DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [15:0]   disp_q, disp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          wrap;
    logic [3:0]    nib;
    logic [3:0]    zero_hi;
    logic          blank;
    logic [6:0]    pat;
    logic [3:0]    onehot;

    always_comb begin
        disp_d = load ? bcd_number : disp_q;
        wrap   = enable && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (wrap) begin
                idx_d = idx_q + 2'd1;
            end
        end

        case (idx_q)
            2'd0:    nib = disp_q[3:0];
            2'd1:    nib = disp_q[7:4];
            2'd2:    nib = disp_q[11:8];
            default: nib = disp_q[15:12];
        endcase

        // zero_hi[k]: digit k and every digit above it are zero; invalid nibbles are non-zero
        zero_hi    = '0;
        zero_hi[3] = (disp_q[15:12] == 4'd0);
        zero_hi[2] = zero_hi[3] && (disp_q[11:8] == 4'd0);
        zero_hi[1] = zero_hi[2] && (disp_q[7:4] == 4'd0);
        blank      = (BLANK_LEADING != 0) && (idx_q != 2'd0) && zero_hi[idx_q];

        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        if (blank) begin
            pat = 7'h00;
        end

        onehot = 4'b0001 << idx_q;
        seg_d  = SEG_OFF;
        an_d   = AN_OFF;
        if (enable) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
            an_d  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
        fd_d = wrap && (idx_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q <= 16'h0000;
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
            fd_q   <= 1'b0;
        end else begin
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            fd_q   <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = DP_OFF;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - scoreboard bench for bcd_display_scanner
module tb_bcd_display_scanner;

    localparam int DIV = 4;
    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bcd_number = 16'h0000;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb, fd, fd_nb;
    logic [3:0]  an, an_nb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) u_dut (
        .clk(clk), .reset(reset), .bcd_number(bcd_number), .load(load), .enable(enable),
        .seg(seg), .dp(dp), .an(an), .frame_done(fd)
    );

    bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) u_dut_nb (
        .clk(clk), .reset(reset), .bcd_number(bcd_number), .load(load), .enable(enable),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb), .frame_done(fd_nb)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg_nb;
        logic       fd;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_disp = 16'h0000;
    int          m_cnt = 0;
    int          m_idx = 0;

    function automatic logic [6:0] m_seg(input logic [15:0] v, input int d, input bit lead);
        logic [15:0] hi;
        logic [3:0]  n;
        logic [6:0]  p;
        hi = v >> (4 * d);
        n  = hi[3:0];
        if (lead && d > 0 && hi == 16'h0) p = 7'h00;
        else if (n > 4'd9)                p = 7'h40;
        else                              p = GLYPH[n];
        return ~p;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.an = 4'hF; e.seg = 7'h7F; e.seg_nb = 7'h7F; e.fd = 1'b0;
        if (!reset && enable) begin
            e.an     = ~(4'b0001 << m_idx);
            e.seg    = m_seg(m_disp, m_idx, 1'b1);
            e.seg_nb = m_seg(m_disp, m_idx, 1'b0);
            e.fd     = (m_cnt == DIV - 1) && (m_idx == 3);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        sb_q.push_back(predict());
        if (reset) begin
            m_disp <= 16'h0000;
            m_cnt  <= 0;
            m_idx  <= 0;
        end else begin
            if (load) m_disp <= bcd_number;
            if (enable) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt <= 0;
                    m_idx <= (m_idx + 1) % 4;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check_eq("sb_an", 16'(an), 16'(sb_q[0].an));
            check_eq("sb_seg", 16'(seg), 16'(sb_q[0].seg));
            check_eq("sb_fd", 16'(fd), 16'(sb_q[0].fd));
            check_eq("sb_dp", 16'(dp), 16'd1);
            check_eq("sb_an_nb", 16'(an_nb), 16'(sb_q[0].an));
            check_eq("sb_seg_nb", 16'(seg_nb), 16'(sb_q[0].seg_nb));
            check_eq("sb_fd_nb", 16'(fd_nb), 16'(sb_q[0].fd));
            check_eq("sb_dp_nb", 16'(dp_nb), 16'd1);
            void'(sb_q.pop_front());
        end
    end

    task automatic wait_enter(input string tag, input logic [3:0] want);
        int n = 0;
        logic [3:0] prev;
        prev = an;
        @(negedge clk);
        while (!(an == want && prev != want) && n < 64) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_enter"}, 16'(an), 16'(want));
    endtask

    task automatic expect_digit(input string tag, input logic [3:0] want_an,
                                input logic [6:0] want_seg, input logic [6:0] want_nb);
        wait_enter(tag, want_an);
        for (int i = 0; i < DIV; i++) begin
            check_eq({tag, "_an"}, 16'(an), 16'(want_an));
            check_eq({tag, "_seg"}, 16'(seg), 16'(want_seg));
            check_eq({tag, "_seg_nb"}, 16'(seg_nb), 16'(want_nb));
            if (i < DIV - 1) @(negedge clk);
        end
    endtask

    task automatic load_value(input logic [15:0] v);
        bcd_number = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int n;
        int frames;
        int held;

        repeat (3) @(negedge clk);
        check_eq("rst_an", 16'(an), 16'hF);
        check_eq("rst_seg", 16'(seg), 16'h7F);
        check_eq("rst_fd", 16'(fd), 16'h0);

        reset = 1'b0;
        enable = 1'b1;
        load_value(16'h1234);
        expect_digit("t1_d0", 4'b1110, 7'h19, 7'h19);
        expect_digit("t1_d1", 4'b1101, 7'h30, 7'h30);
        expect_digit("t1_d2", 4'b1011, 7'h24, 7'h24);
        expect_digit("t1_d3", 4'b0111, 7'h79, 7'h79);
        frames = 0;
        for (int i = 0; i < 8 * DIV; i++) begin
            @(negedge clk);
            if (fd === 1'b1) frames++;
        end
        check_eq("t1_frames", 16'(frames), 16'd2);

        load_value(16'h0007);
        expect_digit("t2_d0", 4'b1110, 7'h78, 7'h78);
        expect_digit("t2_d1", 4'b1101, 7'h7F, 7'h40);
        expect_digit("t2_d2", 4'b1011, 7'h7F, 7'h40);
        expect_digit("t2_d3", 4'b0111, 7'h7F, 7'h40);

        load_value(16'h0000);
        expect_digit("t3a_d0", 4'b1110, 7'h40, 7'h40);
        expect_digit("t3a_d1", 4'b1101, 7'h7F, 7'h40);
        expect_digit("t3a_d2", 4'b1011, 7'h7F, 7'h40);
        expect_digit("t3a_d3", 4'b0111, 7'h7F, 7'h40);
        load_value(16'h0A05);
        expect_digit("t3b_d0", 4'b1110, 7'h12, 7'h12);
        expect_digit("t3b_d1", 4'b1101, 7'h40, 7'h40);
        expect_digit("t3b_d2", 4'b1011, 7'h3F, 7'h3F);
        expect_digit("t3b_d3", 4'b0111, 7'h7F, 7'h40);

        wait_enter("t4", 4'b1011);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t4_rst_an", 16'(an), 16'hF);
        check_eq("t4_rst_seg", 16'(seg), 16'h7F);
        reset = 1'b0;
        expect_digit("t4_d0", 4'b1110, 7'h40, 7'h40);

        load_value(16'h1234);
        wait_enter("t5", 4'b1101);
        held = 1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t5_off_an", 16'(an), 16'hF);
        check_eq("t5_off_seg", 16'(seg), 16'h7F);
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (an !== 4'b1011 && n < 32) begin
            if (an === 4'b1101) held++;
            @(negedge clk);
            n++;
        end
        check_eq("t5_held", 16'(held), 16'(DIV));

        n = 0;
        while (m_cnt != DIV - 1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_align", 16'(m_cnt), 16'(DIV - 1));
        load_value(16'h5678);
        @(negedge clk);
        load_value(16'h9999);
        check_eq("t6_9999_early", 16'(seg == 7'h10), 16'd0);
        @(negedge clk);
        check_eq("t6_9999", 16'(seg), 16'h10);
        repeat (3 * DIV) @(negedge clk);

        enable = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumes the 16-bit packed BCD word {thousands, hundreds, tens, ones} produced by the fixed-point BCD converter stage.
- Drives a time-multiplexed 4-digit common-anode 7-segment display.
- Latches a new value on a load strobe and scans the digits with a programmable refresh divider.
- Applies leading-zero blanking and shows a dash for invalid BCD nibbles.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is held active; minimum 2.
- BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all four digits.
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (0 = segment lit).
- AN_ACTIVE_LOW, 1, 1 = an outputs active-low.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- bcd_number  input  16  packed BCD {thousands[15:12], hundreds[11:8], tens[7:4], ones[3:0]}.
- load  input  1  sample bcd_number into the display register this cycle.
- enable  input  1  1 = scan and drive the display; 0 = display dark.
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  output  1  decimal point, always off (inactive level per SEG_ACTIVE_LOW).
- an  output  4  digit enables; an[0] = ones … an[3] = thousands.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high; reset has priority over all other inputs.
- Reset state:
  - display register = 16'h0000; refresh counter = 0; scan index = 0.
  - seg = all segments off (7'h7F when SEG_ACTIVE_LOW); dp off.
  - an = all inactive (4'hF when AN_ACTIVE_LOW); frame_done = 0.
- Load: on a rising edge with load=1, the display register takes bcd_number. No validation is done at load time.
- Refresh counter:
  - Width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1 while enable=1.
  - At REFRESH_DIV-1 it wraps to 0 and the scan index advances 0→1→2→3→0.
- frame_done: pulses high for one cycle on the edge where the scan index goes 3→0.
- Enable:
  - enable=0: counter and scan index hold; an all inactive; seg off; frame_done=0.
  - On re-enable, scanning resumes from the held digit.
- Output timing:
  - seg, an and dp are registered; they reflect the display register and scan index of the previous cycle.
  - A load sampled at edge N is visible on the pins after edge N+1.
- Segment decode (active-high internal): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibble 10–15: dash, segment g only (internal 40).
- Blank digit: internal 00.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k (k=1..3) is blank if it and every higher digit are 0.
  - Digit 0 is never blanked; a value of 0 shows "0".
  - An invalid nibble counts as non-zero.
- Only one an bit is active at a time; there is no overlap between digits.
- Simultaneous load and digit advance: both take effect; the new digit shows the new value.
- Reset mid-scan: the next cycle is the full reset state; the scan restarts at digit 0 with a full REFRESH_DIV hold.

Test Plan:
1. REFRESH_DIV=4, reset, enable=1, load 16'h1234 → pins cycle through the four digits, each held 4 cycles:
   - an 1110 / seg 19
   - an 1101 / seg 30
   - an 1011 / seg 24
   - an 0111 / seg 79
   - frame_done pulses once per 16 cycles.
2. Load 16'h0007 → digit 0 seg 78; digits 1–3 seg 7F. Repeat with BLANK_LEADING=0 → digits 1–3 seg 40.
3. Load 16'h0000 → ones seg 40, others 7F. Load 16'h0A05 → digit 2 seg 3F (dash), digit 1 seg 40 (not blanked, because a higher digit is non-zero).
4. Assert reset during digit 2 of the scan → next cycle an=F, seg=7F; after release the scan starts at an 1110 and holds 4 cycles.
5. Drop enable during digit 1 → an=F, seg=7F, counter frozen. Raise enable → digit 1 resumes for its remaining cycles.
6. Load 16'h5678 on the same edge as a digit advance → the first digit shown after the advance uses the 5678 values. A load of 16'h9999 two cycles later is visible on the pins after its edge plus one.
